pipelined_multiplier: RTL and testbench

Parametrised, fully pipelined signed/unsigned integer multiplier producing a double-width HI/LO product, built from registered partial-product accumulation stages. It sits in the execute stage beside the ALU and feeds the HI/LO register pair. It provides multiply throughput of one operation per cycle with a valid/ready handshake, downstream back-pressure, and a flush for exception/branch squashing.

---
 rtl/pipelined_multiplier_if.sv | 27 ++
 rtl/pipelined_multiplier.sv | 105 ++++++++++
 tb/tb_pipelined_multiplier.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_multiplier_if.sv
// Handshake bundle for the pipelined HI/LO multiplier: operand side, result side,
// flush and the busy interlock flag.
interface pipelined_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output flush, in_valid, is_signed, a, b, out_ready,
    input  in_ready, out_valid, hi, lo, busy
  );

  modport slave (
    input  flush, in_valid, is_signed, a, b, out_ready,
    output in_ready, out_valid, hi, lo, busy
  );
endinterface

// File: rtl/pipelined_multiplier.sv
// Fully pipelined signed/unsigned multiplier: operands are reduced to magnitudes, one
// K-bit slice of b is accumulated per stage, and the sign is restored before the HI/LO register.
module pipelined_multiplier #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_multiplier_if.slave bus
);
  localparam int K  = WIDTH / STAGES;
  localparam int PW = 2 * WIDTH;

  typedef struct packed {
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] am;
    logic [WIDTH-1:0] bm;
    logic             neg;
  } stage_t;

  // Adds the partial product of a_mag with the idx-th K-bit slice of b_mag.
  function automatic stage_t step(input stage_t s, input int idx);
    stage_t        r;
    logic [PW-1:0] pp;
    pp    = (PW'(s.am) * PW'(s.bm[idx*K +: K])) << (idx * K);
    r     = s;
    r.acc = s.acc + pp;
    return r;
  endfunction

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg;
  stage_t           in_stage;
  stage_t           last;
  logic             last_v;
  logic             pipe_busy;
  logic [PW-1:0]    result;

  // A stalled result freezes every stage at once, so there is no per-stage skid.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !rst && !bus.flush && adv;
  assign accept       = bus.in_valid && bus.in_ready;

  // The most-negative operand negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  assign a_mag    = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag    = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign neg      = bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  assign in_stage = {{PW{1'b0}}, a_mag, b_mag, neg};

  if (STAGES == 1) begin : g_single
    assign last      = step(in_stage, 0);
    assign last_v    = accept;
    assign pipe_busy = 1'b0;
  end else begin : g_multi
    stage_t            pipe_q [STAGES-1];
    logic [STAGES-2:0] v_q;

    // NOTE: the wide datapath flops carry no reset; the valid bits alone say whether they mean anything.
    always_ff @(posedge clk) begin
      if (adv) begin
        pipe_q[0] <= step(in_stage, 0);
        for (int s = 1; s < STAGES-1; s++) begin
          pipe_q[s] <= step(pipe_q[s-1], s);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= '0;
      end else if (bus.flush) begin
        v_q <= '0;
      end else if (adv) begin
        v_q <= (v_q << 1) | (STAGES-1)'(accept);
      end
    end

    assign last      = step(pipe_q[STAGES-2], STAGES-1);
    assign last_v    = v_q[STAGES-2];
    assign pipe_busy = |v_q;
  end

  assign result = last.neg ? -last.acc : last.acc;

  // NOTE: all state updates use non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.hi        <= '0;
      bus.lo        <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= last_v;
      if (last_v) begin
        {bus.hi, bus.lo} <= result;
      end
    end
  end

  assign bus.busy = pipe_busy || bus.out_valid;
endmodule

// File: tb/tb_pipelined_multiplier.sv
// Scoreboard bench for pipelined_multiplier: directed and random products on a 32x4 instance,
// stall/flush behaviour, plus random sweeps and mid-flight reset on smaller configurations.
module tb_pipelined_multiplier;
  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   sweep_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    cyc = 0;
    total = 0;
    bad = 0;
    sweep_done = 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: interpret operands as w-bit signed or unsigned integers, multiply, keep 2*w bits.
  function automatic logic [63:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    longint      sx;
    longint      sy;
    logic [63:0] mask;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return 64'(sx * sy) & mask;
  endfunction

  // ---------------- main 32x4 instance ----------------
  pipelined_multiplier_if #(.WIDTH(32)) m ();
  pipelined_multiplier #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .rst(rst), .bus(m));

  exp_t        m_sb[$];
  bit          m_prev_stall;
  logic [63:0] m_prev_prod;
  bit          m_lat;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      m_prev_stall = 1'b0;
    end else begin
      if (m_prev_stall) begin
        check("stall_hold", {m.hi, m.lo}, m_prev_prod);
        check("stall_valid", m.out_valid, 1);
      end
      if (m.out_valid && m.out_ready) begin
        if (m_sb.size() == 0) begin
          check("unexpected_out", m.out_valid, 0);
        end else begin
          e = m_sb.pop_front();
          check("product", {m.hi, m.lo}, e.prod);
          if (m_lat) check("latency", 64'(cyc), 64'(e.cyc + 4));
        end
      end
      m_prev_stall = m.out_valid && !m.out_ready;
      m_prev_prod  = {m.hi, m.lo};
    end
  end

  task automatic send(input logic s, input logic [31:0] x, input logic [31:0] y);
    int waited;
    waited = 0;
    m.in_valid  = 1'b1;
    m.is_signed = s;
    m.a         = x;
    m.b         = y;
    #1;
    while (!m.in_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (m.in_ready) m_sb.push_back('{prod: model(32, x, y, s), cyc: cyc});
    else check("send_timeout", m.in_ready, 1);
    @(negedge clk);
    m.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [63:0] want);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      #3;
      check({name, "_busy"}, m.busy, 1);
      if (m.out_valid) begin
        seen = 1'b1;
        check(name, {m.hi, m.lo}, want);
      end
      @(negedge clk);
    end
    if (!seen) check({name, "_timeout"}, m.out_valid, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (m_sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(m_sb.size()), 0);
  endtask

  initial begin
    int n;
    m.flush     = 1'b0;
    m.in_valid  = 1'b0;
    m.is_signed = 1'b0;
    m.a         = '0;
    m.b         = '0;
    m.out_ready = 1'b1;
    m_lat       = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("rst_in_ready", m.in_ready, 0);
    check("rst_out_valid", m.out_valid, 0);
    check("rst_busy", m.busy, 0);
    check("rst_hilo", {m.hi, m.lo}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("first_in_ready", m.in_ready, 1);

    // Directed corner products.
    send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_result("uu_max", 64'hFFFF_FFFE_0000_0001);
    #3 check("idle_busy", m.busy, 0);
    @(negedge clk);
    send(1'b1, 32'hFFFF_FFF9, 32'd3);
    expect_result("s_neg7x3", 64'hFFFF_FFFF_FFFF_FFEB);
    send(1'b1, 32'h8000_0000, 32'h8000_0000);
    expect_result("s_minxmin", 64'h4000_0000_0000_0000);

    // Back-to-back random mix; exact latency per item implies consecutive out_valid.
    for (int i = 0; i < 8; i++) send(1'($urandom_range(0, 1)), $urandom, $urandom);
    drain("b2b_drain");

    // Back-pressure: hold out_ready low across the first result for 5 cycles.
    m_lat = 1'b0;
    m.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      begin
        int w;
        w = 0;
        while (!m.out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        check("stall_first_valid", m.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
          #2;
          check("stall_in_ready", m.in_ready, 0);
          @(negedge clk);
        end
        m.out_ready = 1'b1;
      end
    join
    drain("stall_drain");
    m_lat = 1'b1;

    // Flush three in-flight operations; the flush-cycle operand must not be taken.
    for (int i = 0; i < 3; i++) send(1'($urandom_range(0, 1)), $urandom, $urandom);
    m.flush     = 1'b1;
    m.in_valid  = 1'b1;
    m.is_signed = 1'b0;
    m.a         = 32'h1234;
    m.b         = 32'h5678;
    m_sb.delete();
    #1;
    check("flush_in_ready", m.in_ready, 0);
    check("flush_busy_before", m.busy, 1);
    @(negedge clk);
    m.flush    = 1'b0;
    m.in_valid = 1'b0;
    #2;
    check("flush_busy_after", m.busy, 0);
    check("flush_out_valid", m.out_valid, 0);
    repeat (7) @(negedge clk);
    send(1'b0, 32'd1000, 32'd77);
    expect_result("post_flush", 64'd77000);
    drain("final_drain");

    n = 0;
    while (sweep_done < 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("sweep_done", 64'(sweep_done), 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- parameter sweep instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W = (gi == 2) ? 16 : 8;
    localparam int S = (gi == 0) ? 1 : ((gi == 1) ? 8 : 2);

    logic rst_s;
    pipelined_multiplier_if #(.WIDTH(W)) bus ();
    pipelined_multiplier #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst_s), .bus(bus));

    exp_t        q[$];
    bit          prev_stall;
    logic [63:0] prev_prod;

    always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst_s) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("sweep_stall_hold", 64'({bus.hi, bus.lo}), prev_prod);
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check("sweep_unexpected_out", bus.out_valid, 0);
          end else begin
            e = q.pop_front();
            check("sweep_product", 64'({bus.hi, bus.lo}), e.prod);
            check("sweep_latency", 64'(cyc), 64'(e.cyc + S));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_prod  = 64'({bus.hi, bus.lo});
      end
    end

    initial begin
      int n;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.is_signed = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      rst_s = 1'b0;
      #1 rst_s = 1'b1;
      repeat (3) @(negedge clk);
      rst_s = 1'b0;

      for (int k = 0; k < 20; k++) begin
        bus.in_valid = 1'b1;
        if (k == 0) begin
          bus.is_signed = 1'b1;
          bus.a = W'(1) << (W - 1);
          bus.b = W'(1) << (W - 1);
        end else if (k == 1) begin
          bus.is_signed = 1'b0;
          bus.a = '1;
          bus.b = '1;
        end else begin
          bus.is_signed = 1'($urandom_range(0, 1));
          bus.a = W'($urandom);
          bus.b = W'($urandom);
        end
        #1;
        check("sweep_in_ready", bus.in_ready, 1);
        if (bus.in_ready)
          q.push_back('{prod: model(W, 32'(bus.a), 32'(bus.b), bus.is_signed), cyc: cyc});
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("sweep_drain", 64'(q.size()), 0);

      // Fill the pipe behind a stalled result, then reset asynchronously mid-cycle.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.is_signed = 1'b0;
      bus.a         = '1;
      bus.b         = '1;
      n = 0;
      while (!bus.out_valid && n < S + 10) begin
        @(negedge clk);
        n++;
      end
      check("sweep_fill", bus.out_valid, 1);
      bus.in_valid = 1'b0;
      #3 rst_s = 1'b1;
      #1;
      check("sweep_rst_out_valid", bus.out_valid, 0);
      check("sweep_rst_hilo", 64'({bus.hi, bus.lo}), 0);
      check("sweep_rst_busy", bus.busy, 0);
      check("sweep_rst_in_ready", bus.in_ready, 0);
      q.delete();
      @(negedge clk);
      #3 rst_s = 1'b0;
      bus.out_ready = 1'b1;
      repeat (S + 4) @(negedge clk);
      check("sweep_post_rst_idle", bus.busy, 0);
      sweep_done++;
    end
  end
endmodule
